// File: rtl/lc4_insn_cache_pkg.sv
// Shared definitions for the LC4 instruction cache: FSM encoding and the
// miss latency constant shared with the memory delay line.
package lc4_insn_cache_pkg;

  localparam int DEFAULT_MISS_LATENCY = 8;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

endpackage

// File: rtl/lc4_cache_array.sv
// Direct-mapped valid/tag/data storage: combinational read, one write port,
// synchronous whole-array invalidate, asynchronous reset of the valid bits.
module lc4_cache_array #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [15:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [15:0]           wr_data,
  input  logic                  inv
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [15:0]         data_mem [LINES];

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (inv) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays have no reset; the valid bits alone make stale contents harmless.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/lc4_insn_cache.sv
// Direct-mapped instruction cache in front of the LC4 memory i1 port.
// Hits are served combinationally; a miss holds the address for the memory latency.
module lc4_insn_cache
  import lc4_insn_cache_pkg::*;
#(
  parameter int INDEX_BITS   = 4,
  parameter int MISS_LATENCY = DEFAULT_MISS_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gwe,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  input  logic        flush,
  output logic [15:0] insn_out,
  output logic        hit,
  output logic        stall,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data
);

  localparam int TAG_BITS = 16 - INDEX_BITS;
  localparam int CNT_BITS = $clog2(MISS_LATENCY + 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(MISS_LATENCY);

  state_t              state;
  logic [CNT_BITS-1:0] cnt;
  logic [15:0]         miss_addr;
  logic                drop;

  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [15:0]           rd_data;
  logic                  lookup_hit;
  logic                  fill;
  logic                  install;

  assign lookup_hit = rd_valid && (rd_tag == req_addr[15:INDEX_BITS]);
  assign fill       = gwe && (state == MISS) && (cnt == CNT_LAST);
  // A flush seen on the fill edge itself also suppresses the install.
  assign install    = fill && !drop && !flush;

  lc4_cache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (req_addr[INDEX_BITS-1:0]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (install),
    .wr_idx  (miss_addr[INDEX_BITS-1:0]),
    .wr_tag  (miss_addr[15:INDEX_BITS]),
    .wr_data (mem_data),
    .inv     (gwe && flush)
  );

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    hit      = 1'b0;
    stall    = 1'b1;
    insn_out = 16'h0000;
    mem_addr = miss_addr;
    if (state == IDLE) begin
      hit      = req_valid && lookup_hit;
      stall    = req_valid && !lookup_hit;
      insn_out = (req_valid && lookup_hit) ? rd_data : 16'h0000;
      mem_addr = req_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      miss_addr <= 16'h0000;
      drop      <= 1'b0;
    end else if (gwe) begin
      case (state)
        IDLE: begin
          if (req_valid && !lookup_hit) begin
            miss_addr <= req_addr;
            cnt       <= CNT_BITS'(1);
            state     <= MISS;
          end
        end
        MISS: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            drop  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_BITS'(1);
            if (flush) drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc4_insn_cache.sv
// Self-checking bench: directed scenarios plus random traffic against a
// line-table / pending-miss reference model and a gwe-gated memory delay line.
module tb_lc4_insn_cache;

  localparam int IB    = 4;
  localparam int ML    = 8;
  localparam int LINES = 1 << IB;

  logic        clk = 1'b0;
  logic        rst;
  logic        gwe;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        flush;
  logic [15:0] insn_out;
  logic        hit;
  logic        stall;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lc4_insn_cache #(.INDEX_BITS(IB), .MISS_LATENCY(ML)) dut (
    .clk      (clk),
    .rst      (rst),
    .gwe      (gwe),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .flush    (flush),
    .insn_out (insn_out),
    .hit      (hit),
    .stall    (stall),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  // Memory image and gwe-gated delay line standing in for the i1 port.
  logic [15:0] mem_img [logic [15:0]];
  logic [15:0] pipe [ML];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[7:0], a[15:8]} ^ 16'h5AA5;
  endfunction

  always @(posedge clk) begin
    if (gwe) begin
      pipe[0] <= mem_addr;
      for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb mem_data = mem_word(pipe[ML-1]);

  // Reference model: table of installed lines plus one pending miss countdown.
  bit          m_valid [LINES];
  logic [15:0] m_addr  [LINES];
  logic [15:0] m_data  [LINES];
  bit          pend;
  logic [15:0] pend_addr;
  int          pend_left;
  bit          pend_drop;

  logic last_hit;
  logic [15:0] last_insn;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_lookup(input logic [15:0] a);
    int i = int'(a) % LINES;
    return m_valid[i] && (m_addr[i] == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    pend = 0;
    pend_drop = 0;
    pend_left = 0;
  endtask

  task automatic model_edge();
    if (!gwe) return;
    if (pend) begin
      pend_left--;
      if (flush) pend_drop = 1;
      if (pend_left == 0) begin
        if (!pend_drop) begin
          m_valid[int'(pend_addr) % LINES] = 1;
          m_addr[int'(pend_addr) % LINES]  = pend_addr;
          m_data[int'(pend_addr) % LINES]  = mem_word(pend_addr);
        end
        pend = 0;
        pend_drop = 0;
      end
    end else if (req_valid && !model_lookup(req_addr)) begin
      pend      = 1;
      pend_addr = req_addr;
      pend_left = ML;
      pend_drop = 0;
    end
    if (flush) for (int i = 0; i < LINES; i++) m_valid[i] = 0;
  endtask

  // One clock: drive inputs, compare at the falling edge, advance the model.
  task automatic step(input logic rv, input logic [15:0] a, input logic fl, input logic g);
    logic        e_hit;
    logic [15:0] e_insn, e_maddr;
    req_valid = rv;
    req_addr  = a;
    flush     = fl;
    gwe       = g;
    @(negedge clk);
    if (pend) begin
      e_hit = 0; e_insn = 16'h0000; e_maddr = pend_addr;
    end else begin
      e_hit   = rv && model_lookup(a);
      e_insn  = e_hit ? m_data[int'(a) % LINES] : 16'h0000;
      e_maddr = a;
    end
    check("hit", 16'(hit), 16'(e_hit));
    check("stall", 16'(stall), 16'(pend || (rv && !e_hit)));
    check("insn_out", insn_out, e_insn);
    check("mem_addr", mem_addr, e_maddr);
    last_hit  = hit;
    last_insn = insn_out;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Fetch one address until it hits; n counts the stalled steps before the hit.
  task automatic fetch(input logic [15:0] a, input int lo_start, input int lo_len, output int n);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      step(1'b1, a, 1'b0, !(k >= lo_start && k < lo_start + lo_len));
      if (last_hit) break;
      n++;
    end
    if (!last_hit) check("fetch_timeout", 16'(last_hit), 16'h0001);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_hit", 16'(hit), 16'h0000);
    check("rst_insn", insn_out, 16'h0000);
    check("rst_stall", 16'(stall), 16'(req_valid));
    check("rst_mem_addr", mem_addr, req_addr);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; gwe = 1'b1; req_valid = 1'b0; req_addr = 16'h0000; flush = 1'b0;
    mem_img[16'h0000] = 16'h1234;
    mem_img[16'h0010] = 16'hBEEF;
    #1;
    do_reset();

    // Cold miss on 0x0000: nine stall cycles, then hit with the memory word.
    fetch(16'h0000, 99, 0, n);
    check("miss0_stalls", 16'(n), 16'd9);
    check("miss0_insn", last_insn, 16'h1234);
    step(1'b1, 16'h0000, 1'b0, 1'b1);
    check("rehit0", 16'(last_hit), 16'h0001);

    // Conflict on index 0 between tags 0 and 1.
    fetch(16'h0010, 99, 0, n);
    check("miss10_stalls", 16'(n), 16'd9);
    check("miss10_insn", last_insn, 16'hBEEF);
    fetch(16'h0000, 99, 0, n);
    check("evict0_stalls", 16'(n), 16'd9);

    // Request changes mid-miss; the original miss still fills.
    step(1'b1, 16'h0003, 1'b0, 1'b1);
    for (int k = 0; k < ML; k++) step(1'b1, 16'h0005, 1'b0, 1'b1);
    step(1'b1, 16'h0005, 1'b0, 1'b1);
    check("miss5_after_3", 16'(last_hit), 16'h0000);
    fetch(16'h0005, 99, 0, n);
    fetch(16'h0003, 99, 0, n);
    check("line3_installed", 16'(n), 16'd0);

    // Flush in MISS cycle 4 drops the fill and invalidates everything.
    step(1'b1, 16'h0007, 1'b0, 1'b1);
    for (int k = 1; k <= ML; k++) step(1'b1, 16'h0007, k == 4, 1'b1);
    fetch(16'h0007, 99, 0, n);
    check("flush_drop7", 16'(n), 16'd9);
    step(1'b1, 16'h0000, 1'b0, 1'b1);
    check("flush_inval0", 16'(last_hit), 16'h0000);
    fetch(16'h0000, 99, 0, n);

    // Five gwe-low cycles mid-miss stretch the penalty by five.
    fetch(16'h0042, 3, 5, n);
    check("gwe_stretch", 16'(n), 16'd14);

    // Reset mid-miss abandons it; the line is not present afterwards.
    step(1'b1, 16'h0020, 1'b0, 1'b1);
    step(1'b1, 16'h0020, 1'b0, 1'b1);
    step(1'b1, 16'h0020, 1'b0, 1'b1);
    do_reset();
    fetch(16'h0020, 99, 0, n);
    check("post_rst_miss", 16'(n), 16'd9);

    // Random traffic over four tags so hits, conflicts and flushes all occur.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 8,
             16'({$urandom_range(0, 3), 4'($urandom_range(0, 15))}),
             $urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < 85);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
